// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: memory opcode ranges and the memory-stage FSM states.
package pipe_pkg;

   localparam logic [4:0] OP_MEM_W_LO = 5'd3;
   localparam logic [4:0] OP_MEM_W_HI = 5'd5;
   localparam logic [4:0] OP_MEM_D_LO = 5'd6;
   localparam logic [4:0] OP_MEM_D_HI = 5'd8;
   localparam logic [4:0] OP_MEM_B_LO = 5'd9;
   localparam logic [4:0] OP_MEM_B_HI = 5'd11;

   typedef enum logic [1:0] {
      RUN,
      WAIT,
      HALTED
   } stage_state_t;

   function automatic logic in_range(input logic [4:0] op, input logic [4:0] lo,
                                     input logic [4:0] hi);
      return (op >= lo) && (op <= hi);
   endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: selects the addressed word, halfword or byte and zero-extends it.
module load_align
   import pipe_pkg::*;
(
   input  logic [4:0]  opcode,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   // NOTE: assigning a default first on every path keeps always_comb free of inferred latches.
   always_comb begin
      data = rdata;
      if (in_range(opcode, OP_MEM_D_LO, OP_MEM_D_HI)) begin
         data = {16'h0000, rdata[16*addr_lo[1] +: 16]};
      end else if (in_range(opcode, OP_MEM_B_LO, OP_MEM_B_HI)) begin
         data = {24'h000000, rdata[8*addr_lo +: 8]};
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: waits on the data-memory handshake, aligns loads, registers toward writeback.
// Optional misaligned-access detection is enabled by defining MEM_STAGE_MISALIGN_CHECK_EN.
module mem_stage
   import pipe_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bubble_in,
   input  logic        halt_in,
   input  logic [4:0]  opcode,
   input  logic [4:0]  tgt_1,
   input  logic [4:0]  tgt_2,
   input  logic [31:0] result_1,
   input  logic [31:0] result_2,
   input  logic [31:0] addr,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        stall_out,
   output logic [4:0]  fwd_tgt_1,
   output logic [4:0]  fwd_tgt_2,
   output logic [31:0] fwd_result_1,
   output logic [31:0] fwd_result_2,
   output logic        fwd_is_load,
   output logic [31:0] wb_result_1,
   output logic [31:0] wb_result_2,
   output logic [4:0]  wb_tgt_1,
   output logic [4:0]  wb_tgt_2,
   output logic        wb_bubble,
   output logic        wb_halt,
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
   output logic        misalign_out,
`endif
   output logic        bus_err
);

   stage_state_t     state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [31:0]      load_data;
   logic             active, misaligned, capture, retire, set_err;
   logic             unused_addr;

   assign unused_addr = ^addr[31:2];

   load_align u_align (
      .opcode  (opcode),
      .addr_lo (addr[1:0]),
      .rdata   (mem_rdata),
      .data    (load_data)
   );

   assign active = !bubble_in && (is_load || is_store);

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
   assign misaligned = active &&
      ((in_range(opcode, OP_MEM_W_LO, OP_MEM_W_HI) && (addr[1:0] != 2'b00)) ||
       (in_range(opcode, OP_MEM_D_LO, OP_MEM_D_HI) && addr[0]));
`else
   assign misaligned = 1'b0;
`endif

   assign fwd_tgt_1    = bubble_in ? 5'd0 : tgt_1;
   assign fwd_tgt_2    = bubble_in ? 5'd0 : tgt_2;
   assign fwd_result_1 = result_1;
   assign fwd_result_2 = result_2;
   assign fwd_is_load  = is_load && !bubble_in;

   // capture: slot goes to writeback; retire: writeback sees a bubble instead.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      stall_out = 1'b0;
      capture   = 1'b0;
      retire    = 1'b0;
      set_err   = 1'b0;
      case (state)
         RUN: begin
            if (misaligned) begin
               retire = 1'b1;
            end else if (active && !mem_ready) begin
               stall_out = 1'b1;
               retire    = 1'b1;
               state_nx  = WAIT;
               cnt_nx    = CNT_W'(1);
            end else begin
               capture = 1'b1;
               if (halt_in && !bubble_in) state_nx = HALTED;
            end
         end
         WAIT: begin
            if (mem_ready) begin
               capture  = 1'b1;
               cnt_nx   = '0;
               state_nx = (halt_in && !bubble_in) ? HALTED : RUN;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
               retire   = 1'b1;
               set_err  = 1'b1;
               cnt_nx   = '0;
               state_nx = RUN;
            end else begin
               stall_out = 1'b1;
               if (cnt != '1) cnt_nx = cnt + 1'b1;
            end
         end
         HALTED: ;
         default: state_nx = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         cnt     <= '0;
         bus_err <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (set_err) bus_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_result_1 <= '0;
         wb_result_2 <= '0;
         wb_tgt_1    <= '0;
         wb_tgt_2    <= '0;
         wb_bubble   <= 1'b1;
         wb_halt     <= 1'b0;
      end else if (capture) begin
         wb_result_1 <= is_load ? load_data : result_1;
         wb_result_2 <= result_2;
         wb_tgt_1    <= bubble_in ? 5'd0 : tgt_1;
         wb_tgt_2    <= bubble_in ? 5'd0 : tgt_2;
         wb_bubble   <= bubble_in;
         wb_halt     <= halt_in && !bubble_in;
      end else if (retire) begin
         wb_tgt_1  <= '0;
         wb_tgt_2  <= '0;
         wb_bubble <= 1'b1;
      end
   end

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_out <= 1'b0;
      else        misalign_out <= (state == RUN) && misaligned;
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: cycle model of the stage rules plus directed literal checks.
module tb_mem_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bubble_in, halt_in, is_load, is_store, mem_ready;
   logic [4:0]  opcode, tgt_1, tgt_2;
   logic [31:0] result_1, result_2, addr, mem_rdata;
   logic        stall_out, fwd_is_load, wb_bubble, wb_halt, bus_err;
   logic [4:0]  fwd_tgt_1, fwd_tgt_2, wb_tgt_1, wb_tgt_2;
   logic [31:0] fwd_result_1, fwd_result_2, wb_result_1, wb_result_2;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
   logic        misalign_out;
`endif

   int total = 0;
   int bad   = 0;
   int stall_seen = 0;
   int base;

   mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .bubble_in(bubble_in), .halt_in(halt_in), .opcode(opcode),
      .tgt_1(tgt_1), .tgt_2(tgt_2), .result_1(result_1), .result_2(result_2), .addr(addr),
      .is_load(is_load), .is_store(is_store), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_out(stall_out), .fwd_tgt_1(fwd_tgt_1), .fwd_tgt_2(fwd_tgt_2),
      .fwd_result_1(fwd_result_1), .fwd_result_2(fwd_result_2), .fwd_is_load(fwd_is_load),
      .wb_result_1(wb_result_1), .wb_result_2(wb_result_2), .wb_tgt_1(wb_tgt_1),
      .wb_tgt_2(wb_tgt_2), .wb_bubble(wb_bubble), .wb_halt(wb_halt),
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
      .misalign_out(misalign_out),
`endif
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Expected load value, computed by shifting and masking the read word.
   function automatic logic [31:0] exp_load(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] d);
      if (op >= 5'd6 && op <= 5'd8)  return (d >> (int'(a[1]) * 16)) & 32'h0000FFFF;
      if (op >= 5'd9 && op <= 5'd11) return (d >> (int'(a[1:0]) * 8)) & 32'h000000FF;
      return d;
   endfunction

   // Model state: last writeback contents, not-ready cycles seen for the current slot, flags.
   logic [31:0] m_r1, m_r2, e_r1, e_r2;
   logic [4:0]  m_t1, m_t2, e_t1, e_t2;
   logic        m_bub, m_halt, m_err, m_halted, m_mis;
   logic        e_bub, e_halt, e_err, e_halted, e_mis, e_stall, m_act, m_mis_now;
   int          m_nready, e_nready;

   always_comb begin
      e_r1 = m_r1; e_r2 = m_r2; e_t1 = m_t1; e_t2 = m_t2;
      e_bub = m_bub; e_halt = m_halt; e_err = m_err; e_halted = m_halted;
      e_nready = m_nready; e_mis = 1'b0; e_stall = 1'b0;
      m_act = !bubble_in && (is_load || is_store);
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
      m_mis_now = m_act && (((opcode >= 5'd3 && opcode <= 5'd5) && (addr % 4 != 0)) ||
                            ((opcode >= 5'd6 && opcode <= 5'd8) && (addr % 2 != 0)));
`else
      m_mis_now = 1'b0;
`endif
      if (!m_halted) begin
         if (m_mis_now) begin
            e_bub = 1'b1; e_t1 = 5'd0; e_t2 = 5'd0; e_mis = 1'b1; e_nready = 0;
         end else if (m_act && !mem_ready) begin
            if (m_nready + 1 > TO) begin
               e_err = 1'b1; e_nready = 0;
            end else begin
               e_nready = m_nready + 1; e_stall = 1'b1;
            end
            e_bub = 1'b1; e_t1 = 5'd0; e_t2 = 5'd0;
         end else begin
            e_r1 = is_load ? exp_load(opcode, addr, mem_rdata) : result_1;
            e_r2 = result_2;
            e_t1 = bubble_in ? 5'd0 : tgt_1;
            e_t2 = bubble_in ? 5'd0 : tgt_2;
            e_bub = bubble_in;
            e_halt = halt_in && !bubble_in;
            e_halted = e_halt;
            e_nready = 0;
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_r1 <= '0; m_r2 <= '0; m_t1 <= '0; m_t2 <= '0; m_bub <= 1'b1; m_halt <= 1'b0;
         m_err <= 1'b0; m_halted <= 1'b0; m_mis <= 1'b0; m_nready <= 0;
      end else begin
         m_r1 <= e_r1; m_r2 <= e_r2; m_t1 <= e_t1; m_t2 <= e_t2; m_bub <= e_bub;
         m_halt <= e_halt; m_err <= e_err; m_halted <= e_halted; m_mis <= e_mis;
         m_nready <= e_nready;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("stall_out", stall_out, e_stall);
         check("fwd_tgt_1", fwd_tgt_1, bubble_in ? 5'd0 : tgt_1);
         check("fwd_tgt_2", fwd_tgt_2, bubble_in ? 5'd0 : tgt_2);
         check("fwd_result_1", fwd_result_1, result_1);
         check("fwd_result_2", fwd_result_2, result_2);
         check("fwd_is_load", fwd_is_load, is_load && !bubble_in);
         check("wb_result_1", wb_result_1, m_r1);
         check("wb_result_2", wb_result_2, m_r2);
         check("wb_tgt_1", wb_tgt_1, m_t1);
         check("wb_tgt_2", wb_tgt_2, m_t2);
         check("wb_bubble", wb_bubble, m_bub);
         check("wb_halt", wb_halt, m_halt);
         check("bus_err", bus_err, m_err);
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
         check("misalign_out", misalign_out, m_mis);
`endif
         if (stall_out) stall_seen <= stall_seen + 1;
      end
   end

   task automatic slot(input logic bub, input logic hlt, input logic [4:0] op,
                       input logic [4:0] t1, input logic [4:0] t2, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] a, input logic ld,
                       input logic st, input logic [31:0] rd, input logic rdy);
      bubble_in = bub; halt_in = hlt; opcode = op; tgt_1 = t1; tgt_2 = t2;
      result_1 = r1; result_2 = r2; addr = a; is_load = ld; is_store = st;
      mem_rdata = rd; mem_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      slot(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      tick(); tick();
      check("reset wb_bubble", wb_bubble, 1'b1);
      check("reset wb_tgt_1", wb_tgt_1, 5'd0);
      check("reset wb_result_1", wb_result_1, 32'h0);
      check("reset wb_halt", wb_halt, 1'b0);
      check("reset bus_err", bus_err, 1'b0);
      rst_n = 1'b1;
      tick();

      // Byte load, lane 2.
      slot(1'b0, 1'b0, 5'd9, 5'd5, 5'd6, 32'h1002, 32'h1003, 32'h1002, 1'b1, 1'b0, 32'hAABBCCDD, 1'b1);
      tick();
      check("byte load data", wb_result_1, 32'h000000BB);
      check("byte load tgt", wb_tgt_1, 5'd5);
      check("byte load bubble", wb_bubble, 1'b0);

      // Double load, upper half, post-increment address passes through.
      slot(1'b0, 1'b0, 5'd6, 5'd7, 5'd8, 32'h2002, 32'h2006, 32'h2002, 1'b1, 1'b0, 32'h12345678, 1'b1);
      tick();
      check("double load data", wb_result_1, 32'h00001234);
      check("double load postinc", wb_result_2, 32'h00002006);

      // Byte load, top lane.
      slot(1'b0, 1'b0, 5'd10, 5'd2, 5'd0, 32'h1003, 32'h1004, 32'h1003, 1'b1, 1'b0, 32'hAABBCCDD, 1'b1);
      tick();
      check("byte lane3 data", wb_result_1, 32'h000000AA);

      // ALU op with memory not ready: no stall, result passes.
      slot(1'b0, 1'b0, 5'd1, 5'd3, 5'd0, 32'h0000CAFE, 32'h1, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0);
      tick();
      check("alu pass", wb_result_1, 32'h0000CAFE);

      // Store, bubble with memory flags set.
      slot(1'b0, 1'b0, 5'd12, 5'd0, 5'd0, 32'h55, 32'h5004, 32'h5000, 1'b0, 1'b1, 32'h0, 1'b1);
      tick();
      slot(1'b1, 1'b0, 5'd9, 5'd7, 5'd7, 32'h1, 32'h2, 32'h3, 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      check("bubble tgt", wb_tgt_1, 5'd0);
      check("bubble flag", wb_bubble, 1'b1);

      // Ready low three cycles.
      base = stall_seen;
      slot(1'b0, 1'b0, 5'd3, 5'd4, 5'd0, 32'h4000, 32'h4004, 32'h4000, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
      repeat (3) tick();
      mem_ready = 1'b1;
      tick();
      check("wait3 stall cycles", stall_seen - base, 3);
      check("wait3 data", wb_result_1, 32'hDEADBEEF);
      check("wait3 tgt", wb_tgt_1, 5'd4);

      // Ready arrives on the timeout cycle: ready wins.
      base = stall_seen;
      slot(1'b0, 1'b0, 5'd4, 5'd11, 5'd0, 32'h6000, 32'h6004, 32'h6000, 1'b1, 1'b0, 32'h600DF00D, 1'b0);
      repeat (4) tick();
      mem_ready = 1'b1;
      tick();
      check("ready wins bus_err", bus_err, 1'b0);
      check("ready wins data", wb_result_1, 32'h600DF00D);
      check("ready wins stall cycles", stall_seen - base, 4);

      // Timeout.
      base = stall_seen;
      slot(1'b0, 1'b0, 5'd5, 5'd12, 5'd1, 32'h7000, 32'h7004, 32'h7000, 1'b1, 1'b0, 32'h11111111, 1'b0);
      repeat (5) tick();
      check("timeout bus_err", bus_err, 1'b1);
      check("timeout tgt", wb_tgt_1, 5'd0);
      check("timeout bubble", wb_bubble, 1'b1);
      check("timeout stall cycles", stall_seen - base, 4);
      slot(1'b0, 1'b0, 5'd3, 5'd6, 5'd0, 32'h8000, 32'h8004, 32'h8000, 1'b1, 1'b0, 32'h0000ABCD, 1'b1);
      repeat (3) tick();
      check("bus_err sticky", bus_err, 1'b1);
      check("after timeout data", wb_result_1, 32'h0000ABCD);

      // Reset during WAIT, then a wait that must not time out early.
      slot(1'b0, 1'b0, 5'd3, 5'd14, 5'd0, 32'h9000, 32'h9004, 32'h9000, 1'b1, 1'b0, 32'h00000005, 1'b0);
      repeat (2) tick();
      #2 rst_n = 1'b0;
      #1;
      check("midwait reset bubble", wb_bubble, 1'b1);
      check("midwait reset bus_err", bus_err, 1'b0);
      check("midwait reset tgt", wb_tgt_1, 5'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      base = stall_seen;
      repeat (4) tick();
      mem_ready = 1'b1;
      tick();
      check("post reset bus_err", bus_err, 1'b0);
      check("post reset data", wb_result_1, 32'h00000005);
      check("post reset stall cycles", stall_seen - base, 4);

      // Halt freezes writeback.
      slot(1'b0, 1'b1, 5'd0, 5'd9, 5'd0, 32'h99, 32'h98, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      check("halt wb_halt", wb_halt, 1'b1);
      check("halt tgt", wb_tgt_1, 5'd9);
      slot(1'b0, 1'b0, 5'd3, 5'd13, 5'd0, 32'hA000, 32'hA004, 32'hA000, 1'b1, 1'b0, 32'h77, 1'b1);
      repeat (2) tick();
      check("halted tgt frozen", wb_tgt_1, 5'd9);
      check("halted data frozen", wb_result_1, 32'h99);
      check("halted wb_halt", wb_halt, 1'b1);
      rst_n = 1'b0;
      idle();
      tick();
      rst_n = 1'b1;
      tick();

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
      base = stall_seen;
      slot(1'b0, 1'b0, 5'd3, 5'd15, 5'd0, 32'h3001, 32'h3005, 32'h3001, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0);
      tick();
      check("misalign pulse", misalign_out, 1'b1);
      check("misalign tgt", wb_tgt_1, 5'd0);
      check("misalign no stall", stall_seen - base, 0);
      idle();
      tick();
      check("misalign pulse end", misalign_out, 1'b0);
      slot(1'b0, 1'b0, 5'd7, 5'd16, 5'd0, 32'h3003, 32'h3005, 32'h3003, 1'b0, 1'b1, 32'h0, 1'b0);
      tick();
      check("misalign store pulse", misalign_out, 1'b1);
      check("misalign store no stall", stall_seen - base, 0);
`else
      slot(1'b0, 1'b0, 5'd3, 5'd15, 5'd0, 32'h3001, 32'h3005, 32'h3001, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1);
      tick();
      check("unaligned word data", wb_result_1, 32'hCAFEF00D);
      check("unaligned word tgt", wb_tgt_1, 5'd15);
      slot(1'b0, 1'b0, 5'd7, 5'd16, 5'd0, 32'h3003, 32'h3005, 32'h3003, 1'b1, 1'b0, 32'hA1B2C3D4, 1'b1);
      tick();
      check("odd double data", wb_result_1, 32'h0000A1B2);
`endif
      idle();
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
